// File: rtl/score_display.sv
// Two-digit multiplexed seven-segment score display with a blinking hold of the
// final score at game over, followed by a steady high-score display.
module score_display #(
  parameter int SCAN_DIV    = 1000,
  parameter int BLINK_DIV   = 250000,
  parameter int HOLD_BLINKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd_ones,
  input  logic [3:0] bcd_tens,
  input  logic       isGameComplete,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       holding
);

  localparam int SCAN_W  = $clog2(SCAN_DIV + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);
  localparam int TOG_W   = $clog2(2 * HOLD_BLINKS + 1);

  typedef enum logic [1:0] {NORMAL, HOLD, SHOW_HIGH} state_t;

  state_t               state, nxt;
  logic [3:0]           dispOnes, dispTens;
  logic                 digitSel;
  logic [SCAN_W-1:0]    scanCnt;
  logic [BLINK_W-1:0]   blinkCnt;
  logic [TOG_W-1:0]     toggleCnt;
  logic                 blankPhase;
  logic                 prevGc;

  logic rise, scan_tc, blink_tc, last_toggle, load, counting;

  assign rise        = isGameComplete & ~prevGc;
  assign scan_tc     = (scanCnt == SCAN_W'(SCAN_DIV - 1));
  assign blink_tc    = (blinkCnt == BLINK_W'(BLINK_DIV - 1));
  assign last_toggle = blink_tc && (toggleCnt == TOG_W'(2 * HOLD_BLINKS - 1));
  // Display freezes exactly while the next state is HOLD.
  assign load        = (nxt != HOLD);
  assign counting    = (state == HOLD) && (nxt == HOLD);

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'h7E;
      4'd1: enc = 7'h30;
      4'd2: enc = 7'h6D;
      4'd3: enc = 7'h79;
      4'd4: enc = 7'h33;
      4'd5: enc = 7'h5B;
      4'd6: enc = 7'h5F;
      4'd7: enc = 7'h70;
      4'd8: enc = 7'h7F;
      4'd9: enc = 7'h7B;
      default: enc = 7'h01;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= NORMAL;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      NORMAL:    if (rise) nxt = HOLD;
      HOLD:      if (!isGameComplete) nxt = NORMAL;
                 else if (last_toggle) nxt = SHOW_HIGH;
      SHOW_HIGH: if (!isGameComplete) nxt = NORMAL;
      default:   nxt = NORMAL;
    endcase
  end

  always_comb begin
    holding = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dispOnes   <= '0;
      dispTens   <= '0;
      digitSel   <= 1'b0;
      scanCnt    <= '0;
      blinkCnt   <= '0;
      toggleCnt  <= '0;
      blankPhase <= 1'b0;
      prevGc     <= 1'b0;
    end else begin
      prevGc <= isGameComplete;
      if (scan_tc) begin
        scanCnt  <= '0;
        digitSel <= ~digitSel;
      end else begin
        scanCnt <= scanCnt + 1'b1;
      end
      if (load) begin
        dispOnes <= bcd_ones;
        dispTens <= bcd_tens;
      end
      // Blink counters run only while staying in HOLD; any other path clears them.
      if (counting) begin
        if (blink_tc) begin
          blinkCnt   <= '0;
          blankPhase <= ~blankPhase;
          toggleCnt  <= toggleCnt + 1'b1;
        end else begin
          blinkCnt <= blinkCnt + 1'b1;
        end
      end else begin
        blinkCnt   <= '0;
        toggleCnt  <= '0;
        blankPhase <= 1'b0;
      end
    end
  end

  always_comb begin
    an = digitSel ? 2'b10 : 2'b01;
    if (blankPhase)                  seg = 7'h00;
    else if (!digitSel)              seg = enc(dispOnes);
    else if (dispTens == 4'd0)       seg = 7'h00;
    else                             seg = enc(dispTens);
  end

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench: driver steps a cycle-level behavioural model and queues the
// expected outputs; a monitor pops and compares one entry per clock.
module tb_score_display;
  localparam int SD = 4, BD = 2, HB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] bcd_ones = '0, bcd_tens = '0;
  logic       isGameComplete = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       holding;

  score_display #(.SCAN_DIV(SD), .BLINK_DIV(BD), .HOLD_BLINKS(HB)) dut (
    .clk(clk), .rst(rst), .bcd_ones(bcd_ones), .bcd_tens(bcd_tens),
    .isGameComplete(isGameComplete), .seg(seg), .an(an), .holding(holding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [1:0] an;
    logic       hold;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0, cyc = 0;

  logic [6:0] segtab [0:15] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F,
                                7'h70, 7'h7F, 7'h7B, 7'h01, 7'h01, 7'h01, 7'h01,
                                7'h01, 7'h01};

  // Model: mode 0=normal 1=hold 2=high; c = cycles since reset, t = cycles in hold.
  int         m_mode = 0, m_c = 0, m_t = 0;
  logic [3:0] m_ones = '0, m_tens = '0;
  logic       m_prev = 1'b0;

  task automatic model_edge(input logic r, input logic gc, input logic [3:0] o, input logic [3:0] tn);
    exp_t e;
    logic tens_ph, blank;
    if (r) begin
      m_mode = 0; m_c = 0; m_t = 0; m_ones = 0; m_tens = 0; m_prev = 0;
    end else begin
      m_c++;
      case (m_mode)
        0: if (gc && !m_prev) begin m_mode = 1; m_t = 0; end
           else begin m_ones = o; m_tens = tn; end
        1: if (!gc) begin m_mode = 0; m_ones = o; m_tens = tn; end
           else begin
             m_t++;
             if (m_t == 2 * HB * BD) begin m_mode = 2; m_ones = o; m_tens = tn; end
           end
        default: begin
          if (!gc) m_mode = 0;
          m_ones = o; m_tens = tn;
        end
      endcase
      m_prev = gc;
    end
    tens_ph = ((m_c / SD) % 2) == 1;
    blank   = (m_mode == 1) && (((m_t / BD) % 2) == 1);
    e.an    = tens_ph ? 2'b10 : 2'b01;
    e.hold  = (m_mode == 1);
    if (blank)               e.seg = 7'h00;
    else if (!tens_ph)       e.seg = segtab[m_ones];
    else if (m_tens == 4'd0) e.seg = 7'h00;
    else                     e.seg = segtab[m_tens];
    q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic gc, input logic [3:0] o, input logic [3:0] tn, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = r; isGameComplete = gc; bcd_ones = o; bcd_tens = tn;
      model_edge(r, gc, o, tn);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (seg !== e.seg) begin
          fails++; $display("FAIL seg cyc=%0d got=%h exp=%h", cyc, seg, e.seg);
        end
        tests++;
        if (an !== e.an) begin
          fails++; $display("FAIL an cyc=%0d got=%b exp=%b", cyc, an, e.an);
        end
        tests++;
        if (holding !== e.hold) begin
          fails++; $display("FAIL holding cyc=%0d got=%b exp=%b", cyc, holding, e.hold);
        end
      end
    end
  end

  initial begin : stim
    logic       gc;
    logic [3:0] o, tn;
    int         run;
    drive(1, 0, 0, 0, 2);
    drive(0, 0, 0, 0, 16);           // 0/0 scan pattern
    drive(0, 0, 4, 3, 10);           // 34
    drive(0, 0, 3, 2, 4);            // 23 on display
    drive(0, 1, 1, 4, 14);           // game over with 41 -> hold, then high score
    drive(0, 0, 7, 1, 4);
    drive(0, 1, 8, 8, 3);            // hold aborted at cycle 3
    drive(0, 0, 5, 6, 6);
    drive(0, 0, 4'hC, 4'hA, 8);      // out-of-range digits show dash
    drive(0, 1, 2, 9, 3);            // into blank phase, then reset
    drive(1, 0, 2, 9, 1);
    drive(0, 0, 2, 9, 6);
    drive(0, 1, 2, 9, 12);           // fresh rising edge re-enters hold
    drive(0, 0, 0, 0, 2);
    gc = 0; o = 0; tn = 0; run = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin gc = ~gc; run = $urandom_range(1, 24); end
      run--;
      if ($urandom_range(0, 3) == 0) begin
        o  = 4'($urandom_range(0, 15));
        tn = 4'($urandom_range(0, 15));
      end
      drive(($urandom_range(0, 149) == 0), gc, o, tn, 1);
    end
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++; $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, 1000, clk cycles each digit stays selected.
REQ-002 SHALL have parameter BLINK_DIV, 250000, clk cycles per blink half-period during final-score hold.
REQ-003 SHALL have parameter HOLD_BLINKS, 3, full off/on blink cycles shown before the high score appears.
REQ-004 SHALL have port clk  input  1  system clock; one clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port bcd_ones  input  4  ones digit from score tracker.
REQ-007 SHALL have port bcd_tens  input  4  tens digit from score tracker.
REQ-008 SHALL have port isGameComplete  input  1  game-over level from score tracker.
REQ-009 SHALL have port seg  output  7  segments {a,b,c,d,e,f,g} = seg[6:0], active-high.
REQ-010 SHALL have port an  output  2  one-hot digit enable: 01 = ones, 10 = tens, active-high.
REQ-011 SHALL have port holding  output  1  high while final score is blinking.

Function
REQ-012 SHALL drive seg/an only from registered state, with no combinational path from inputs.
REQ-013 SHALL keep display registers dispOnes/dispTens, a digit-select bit, scanCnt, blinkCnt, toggleCnt, blankPhase, prevGc and state {NORMAL, HOLD, SHOW_HIGH}.
REQ-014 SHALL scan with scanCnt 0..SCAN_DIV-1, toggling digit select and clearing scanCnt at the terminal count, in every state.
REQ-015 SHALL encode digits as 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B (hex); values 10-15 SHALL show dash 01.
REQ-016 SHALL blank the tens digit (seg=00) when dispTens==0; the ones digit SHALL never be leading-zero blanked.
REQ-017 SHALL force seg=00 when blankPhase==1, regardless of digit; an keeps scanning.
REQ-018 SHALL register prevGc <= isGameComplete each cycle; rising edge = isGameComplete & ~prevGc.
REQ-019 SHALL, in NORMAL, load dispOnes/dispTens from inputs every cycle.
REQ-020 SHALL, on a rising edge seen in NORMAL, enter HOLD without loading the display, freezing the pre-game-over score; blinkCnt, toggleCnt and blankPhase are cleared.
REQ-021 SHALL, in HOLD, count blinkCnt 0..BLINK_DIV-1; at the terminal count, toggle blankPhase and increment toggleCnt.
REQ-022 SHALL move HOLD -> SHOW_HIGH on the toggle making toggleCnt == 2*HOLD_BLINKS (blankPhase returns to 0), loading display registers from inputs on that same edge.
REQ-023 SHALL, in SHOW_HIGH, load display from inputs every cycle, steady (no blanking).
REQ-024 SHALL return to NORMAL from HOLD or SHOW_HIGH on the first cycle isGameComplete==0, clearing blankPhase; HOLD aborted this way SHALL not pass through SHOW_HIGH.
REQ-025 SHALL assert holding iff state==HOLD.
REQ-026 SHALL size toggleCnt/blinkCnt/scanCnt to hold their parameter maxima without wrap.

Reset
REQ-027 SHALL, when rst==1 at a clock edge, set state=NORMAL, dispOnes=dispTens=0, digit select=ones, all counters 0, blankPhase=0, prevGc=0; rst wins over every other event including mid-HOLD.
REQ-028 SHALL output an=01, seg=7E, holding=0 in the first cycle after reset.

Verification (SCAN_DIV=4, BLINK_DIV=2, HOLD_BLINKS=2)
REQ-029 SHALL cover: reset, inputs 0/0 -> an=01 seg=7E for 4 cycles, then an=10 seg=00 for 4 cycles, repeating.
REQ-030 SHALL cover: tens=3, ones=4 -> ones phase seg=33, tens phase seg=79, updated one cycle after input change.
REQ-031 SHALL cover: 23 displayed, then same cycle isGameComplete=1 and digits=4/1 -> holding=1; 23 shown HOLD cycles 1-2 and 5-6, seg=00 cycles 3-4 and 7-8; cycle 9 shows 41, holding=0.
REQ-032 SHALL cover: isGameComplete drops at HOLD cycle 3 -> next cycle NORMAL, seg unblanked, display follows inputs.
REQ-033 SHALL cover: bcd_ones=C, bcd_tens=A -> both digits seg=01.
REQ-034 SHALL cover: rst pulsed during HOLD blank phase -> next cycle an=01, seg=7E, holding=0, and no HOLD re-entry until a fresh isGameComplete rising edge.
